// File: rtl/ym_phase_pkg.sv
// rtl/ym_phase_pkg.sv - shared constants, FSM encoding and width helper for the phase generator
// Purpose: chip-family divider/slot defaults, init-clear FSM state encoding,
//          and the divider counter width function used by every file.
// Ports:   none (package).
package ym_phase_pkg;

  // ym3438: 6 MCLK per internal cycle, 24 slots per frame.
  localparam int YM3438_DIV   = 6;
  localparam int YM3438_SLOTS = 24;

  // ym7101: board-dependent; these are starting values meant to be overridden
  // on the instance.
  localparam int YM7101_DIV   = 7;
  localparam int YM7101_SLOTS = 24;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_HOLD  = 2'd1,
    ST_DRAIN = 2'd2
  } init_state_e;

  // Divider counter width; a 2-period divider still needs one bit.
  function automatic int div_width(input int div);
    return (div <= 2) ? 1 : $clog2(div);
  endfunction

endpackage

// File: rtl/ym_phase_gen_if.sv
// rtl/ym_phase_gen_if.sv - phase generator bus: IC pin in, enables/counters/clear out
// Purpose: bundles the IC input and every timing output of ym_phase_gen.
// Signals: ic (in to generator), c1, c2, div_cnt, slot, sync, ic_cyc (out).
// Modports: master = the generator, slave = the datapath consuming the phases.
interface ym_phase_gen_if #(
  parameter int DIV = ym_phase_pkg::YM3438_DIV
);

  localparam int DW = ym_phase_pkg::div_width(DIV);

  logic          ic;
  logic          c1;
  logic          c2;
  logic [DW-1:0] div_cnt;
  logic [4:0]    slot;
  logic          sync;
  logic          ic_cyc;

  modport master (
    input  ic,
    output c1, c2, div_cnt, slot, sync, ic_cyc
  );

  modport slave (
    output ic,
    input  c1, c2, div_cnt, slot, sync, ic_cyc
  );

endinterface

// File: rtl/ym_phase_div.sv
// rtl/ym_phase_div.sv - MCLK divider with registered c1/c2 enable decode
// Purpose: counts 0..DIV-1 and produces one-MCLK c1/c2 enables per internal cycle.
// Ports:   MCLK, reset (async, active-high) in;
//          div_cnt_o (divider position), wrap_o (next edge returns div_cnt to 0),
//          c1_o, c2_o (registered phase enables) out.
// Parameters: DIV >= 2; C1_POS, C2_POS < DIV and distinct.
module ym_phase_div
  import ym_phase_pkg::*;
#(
  parameter int DIV    = YM3438_DIV,
  parameter int C1_POS = 0,
  parameter int C2_POS = 3
) (
  input  logic                       MCLK,
  input  logic                       reset,
  output logic [div_width(DIV)-1:0]  div_cnt_o,
  output logic                       wrap_o,
  output logic                       c1_o,
  output logic                       c2_o
);

  localparam int            DW   = div_width(DIV);
  localparam logic [DW-1:0] LAST = DW'(DIV - 1);
  localparam logic [DW-1:0] C1_V = DW'(C1_POS);
  localparam logic [DW-1:0] C2_V = DW'(C2_POS);

  logic [DW-1:0] div_q;
  logic [DW-1:0] div_d;
  logic          c1_q;
  logic          c2_q;

  always_comb begin
    div_d = (div_q == LAST) ? '0 : div_q + DW'(1);
  end

  // Enables decode the next count so they line up with div_cnt in the same cycle.
  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      div_q <= LAST;
      c1_q  <= 1'b0;
      c2_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      c1_q  <= (div_d == C1_V);
      c2_q  <= (div_d == C2_V);
    end
  end

  assign div_cnt_o = div_q;
  assign wrap_o    = (div_q == LAST);
  assign c1_o      = c1_q;
  assign c2_o      = c2_q;

endmodule

// File: rtl/ym_phase_gen.sv
// rtl/ym_phase_gen.sv - master-clock phase generator: divider, slot counter, IC clear sequencing
// Purpose: divides MCLK into internal cycles, emits c1/c2, counts slots with a
//          frame sync and stretches the IC pin into the chip-internal clear.
// Ports:   MCLK (clock), reset (async, active-high);
//          bus (master): ic in; c1, c2, div_cnt, slot, sync, ic_cyc out.
// Parameters: DIV >= 2, SLOTS in 2..32, C1_POS/C2_POS < DIV and distinct.
module ym_phase_gen
  import ym_phase_pkg::*;
#(
  parameter int DIV    = YM3438_DIV,
  parameter int SLOTS  = YM3438_SLOTS,
  parameter int C1_POS = 0,
  parameter int C2_POS = 3
) (
  input  logic           MCLK,
  input  logic           reset,
  ym_phase_gen_if.master bus
);

  localparam int         DW        = div_width(DIV);
  localparam logic [4:0] SLOT_LAST = 5'(SLOTS - 1);

  logic [DW-1:0] div_cnt;
  logic          wrap;
  logic          c1;
  logic          c2;

  ym_phase_div #(
    .DIV    (DIV),
    .C1_POS (C1_POS),
    .C2_POS (C2_POS)
  ) u_div (
    .MCLK      (MCLK),
    .reset     (reset),
    .div_cnt_o (div_cnt),
    .wrap_o    (wrap),
    .c1_o      (c1),
    .c2_o      (c2)
  );

  logic        ic_meta_q;
  logic        ic_s_q;
  init_state_e state_q;
  init_state_e state_d;
  logic [4:0]  slot_q;
  logic [4:0]  slot_d;
  logic        sync_q;
  logic        ic_cyc_q;

  always_comb begin
    state_d = state_q;
    if (wrap) begin
      case (state_q)
        ST_IDLE:  if (ic_s_q) state_d = ST_HOLD;
        ST_HOLD:  if (!ic_s_q) state_d = ST_DRAIN;
        ST_DRAIN: begin
          if (ic_s_q)                   state_d = ST_HOLD;
          else if (slot_q == SLOT_LAST) state_d = ST_IDLE;
        end
        default:  state_d = ST_IDLE;
      endcase
    end
  end

  // Slot is pinned to 0 on any wrap that enters, stays in or leaves HOLD, so
  // the drain always starts at slot 0 and re-entry from DRAIN restarts the frame.
  always_comb begin
    slot_d = slot_q;
    if (wrap) begin
      if (state_q == ST_HOLD || state_d == ST_HOLD) slot_d = '0;
      else slot_d = (slot_q == SLOT_LAST) ? '0 : slot_q + 5'd1;
    end
  end

  always_ff @(posedge MCLK or posedge reset) begin
    if (reset) begin
      ic_meta_q <= 1'b0;
      ic_s_q    <= 1'b0;
      state_q   <= ST_IDLE;
      slot_q    <= SLOT_LAST;
      sync_q    <= 1'b1;
      ic_cyc_q  <= 1'b0;
    end else begin
      ic_meta_q <= bus.ic;
      ic_s_q    <= ic_meta_q;
      state_q   <= state_d;
      slot_q    <= slot_d;
      sync_q    <= (slot_d == SLOT_LAST);
      ic_cyc_q  <= (state_d != ST_IDLE);
    end
  end

  assign bus.c1      = c1;
  assign bus.c2      = c2;
  assign bus.div_cnt = div_cnt;
  assign bus.slot    = slot_q;
  assign bus.sync    = sync_q;
  assign bus.ic_cyc  = ic_cyc_q;

endmodule

// File: tb/tb_ym_phase_gen.sv
// tb/tb_ym_phase_gen.sv - directed self-checking bench for ym_phase_gen (default and DIV=4 builds)
module tb_ym_phase_gen;

  logic mclk;
  logic rst;
  int   vectors     = 0;
  int   miscompares = 0;
  int   e           = 0;
  bit   chk_en      = 1'b0;
  bit   u0_free     = 1'b1;
  bit   u1_free     = 1'b1;
  int   cnt;

  ym_phase_gen_if #(.DIV(6)) bus0 ();
  ym_phase_gen_if #(.DIV(4)) bus1 ();

  ym_phase_gen #(.DIV(6), .SLOTS(24), .C1_POS(0), .C2_POS(3)) u0 (
    .MCLK  (mclk),
    .reset (rst),
    .bus   (bus0)
  );

  ym_phase_gen #(.DIV(4), .SLOTS(16), .C1_POS(0), .C2_POS(2)) u1 (
    .MCLK  (mclk),
    .reset (rst),
    .bus   (bus1)
  );

  initial mclk = 1'b0;
  always #5 mclk = ~mclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d at edge %0d", tag, obs, exp, e);
    end
  endtask

  // Advance one MCLK edge and sample 1 time unit later; edge 1 is the first
  // edge after reset release.
  task automatic tick();
    @(posedge mclk);
    #1;
    e++;
    if (chk_en) begin
      chk("div0", bus0.div_cnt, (e - 1) % 6);
      chk("c1_0", bus0.c1, ((e - 1) % 6) == 0);
      chk("c2_0", bus0.c2, ((e - 1) % 6) == 3);
      chk("excl0", bus0.c1 & bus0.c2, 0);
      chk("div1", bus1.div_cnt, (e - 1) % 4);
      chk("c1_1", bus1.c1, ((e - 1) % 4) == 0);
      chk("c2_1", bus1.c2, ((e - 1) % 4) == 2);
      chk("excl1", bus1.c1 & bus1.c2, 0);
      if (u0_free) begin
        chk("slot0", bus0.slot, ((e - 1) / 6) % 24);
        chk("sync0", bus0.sync, (((e - 1) / 6) % 24) == 23);
      end
      if (u1_free) begin
        chk("slot1", bus1.slot, ((e - 1) / 4) % 16);
        chk("sync1", bus1.sync, (((e - 1) / 4) % 16) == 15);
      end
    end
  endtask

  task automatic run_to(input int target);
    while (e < target) tick();
  endtask

  initial begin
    rst = 1'b1;
    bus0.ic = 1'b0;
    bus1.ic = 1'b0;
    repeat (3) @(posedge mclk);
    #1;
    // Reset values
    chk("rst_div0", bus0.div_cnt, 5);
    chk("rst_slot0", bus0.slot, 23);
    chk("rst_sync0", bus0.sync, 1);
    chk("rst_c1_0", bus0.c1, 0);
    chk("rst_c2_0", bus0.c2, 0);
    chk("rst_iccyc0", bus0.ic_cyc, 0);
    chk("rst_div1", bus1.div_cnt, 3);
    chk("rst_slot1", bus1.slot, 15);

    // Test 1: release and first frame steps
    rst = 1'b0;
    e = 0;
    chk_en = 1'b1;
    tick();
    chk("rel_div", bus0.div_cnt, 0);
    chk("rel_c1", bus0.c1, 1);
    chk("rel_slot", bus0.slot, 0);
    chk("rel_sync", bus0.sync, 0);
    run_to(7);
    chk("e7_div", bus0.div_cnt, 0);
    chk("e7_slot", bus0.slot, 1);

    // Test 2: free run through a full frame; slot 23 lasts exactly 6 MCLK
    cnt = 0;
    while (e < 150) begin
      tick();
      if (bus0.sync) cnt++;
      chk("free_iccyc", bus0.ic_cyc, 0);
    end
    chk("sync_width", cnt, 6);

    // Test 3: 10-MCLK ic pulse starting at div_cnt 2
    run_to(153);
    chk("ic_start_div", bus0.div_cnt, 2);
    u0_free = 1'b0;
    bus0.ic = 1'b1;
    run_to(156);
    chk("pre_hold_iccyc", bus0.ic_cyc, 0);
    chk("pre_hold_slot", bus0.slot, 1);
    tick();
    chk("hold_iccyc", bus0.ic_cyc, 1);
    chk("hold_slot", bus0.slot, 0);
    run_to(163);
    bus0.ic = 1'b0;
    run_to(168);
    chk("hold_end_slot", bus0.slot, 0);
    tick();
    chk("drain_slot0", bus0.slot, 0);
    chk("drain_iccyc", bus0.ic_cyc, 1);
    run_to(175);
    chk("drain_slot1", bus0.slot, 1);
    cnt = 0;
    while (e < 312) begin
      tick();
      if (!bus0.ic_cyc) cnt++;
    end
    chk("drain_gap", cnt, 0);
    chk("drain_last_slot", bus0.slot, 23);
    chk("drain_last_sync", bus0.sync, 1);
    tick();
    chk("release_iccyc", bus0.ic_cyc, 0);
    chk("release_slot", bus0.slot, 0);
    chk("release_sync", bus0.sync, 0);

    // Test 4: ic re-asserted in DRAIN at slot 10
    bus0.ic = 1'b1;
    run_to(318);
    chk("ep2_pre_iccyc", bus0.ic_cyc, 0);
    tick();
    chk("ep2_hold", bus0.ic_cyc, 1);
    bus0.ic = 1'b0;
    cnt = 0;
    while (e < 385) begin
      tick();
      if (!bus0.ic_cyc) cnt++;
    end
    chk("ep2_slot10", bus0.slot, 10);
    bus0.ic = 1'b1;
    while (e < 391) begin
      tick();
      if (!bus0.ic_cyc) cnt++;
    end
    chk("ep2_gap", cnt, 0);
    chk("rehold_slot", bus0.slot, 0);
    chk("rehold_iccyc", bus0.ic_cyc, 1);
    bus0.ic = 1'b0;

    // Test 5: reset at div_cnt 4 of slot 7 in DRAIN
    run_to(443);
    chk("pre_rst_slot", bus0.slot, 7);
    chk("pre_rst_div", bus0.div_cnt, 4);
    chk("pre_rst_iccyc", bus0.ic_cyc, 1);
    rst = 1'b1;
    #1;
    chk("mid_rst_div", bus0.div_cnt, 5);
    chk("mid_rst_slot", bus0.slot, 23);
    chk("mid_rst_c1", bus0.c1, 0);
    chk("mid_rst_c2", bus0.c2, 0);
    chk("mid_rst_iccyc", bus0.ic_cyc, 0);
    chk("mid_rst_sync", bus0.sync, 1);
    chk_en = 1'b0;
    tick();
    rst = 1'b0;
    e = 0;
    chk_en = 1'b1;
    u0_free = 1'b1;
    run_to(7);
    chk("re_e7_slot", bus0.slot, 1);
    chk("re_iccyc", bus0.ic_cyc, 0);

    // Test 6: DIV=4 / SLOTS=16 build drains for 16 internal cycles
    run_to(10);
    u1_free = 1'b0;
    bus1.ic = 1'b1;
    run_to(12);
    chk("d4_pre_iccyc", bus1.ic_cyc, 0);
    tick();
    chk("d4_hold_iccyc", bus1.ic_cyc, 1);
    chk("d4_hold_slot", bus1.slot, 0);
    bus1.ic = 1'b0;
    run_to(17);
    chk("d4_drain_slot", bus1.slot, 0);
    run_to(21);
    chk("d4_drain_slot1", bus1.slot, 1);
    cnt = 0;
    while (e < 80) begin
      tick();
      if (!bus1.ic_cyc) cnt++;
    end
    chk("d4_gap", cnt, 0);
    chk("d4_last_slot", bus1.slot, 15);
    chk("d4_last_sync", bus1.sync, 1);
    tick();
    chk("d4_release_iccyc", bus1.ic_cyc, 0);
    chk("d4_release_slot", bus1.slot, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
